e203_nice_csr_resp: RTL and testbench

Responder end of the NICE CSR access channel: receives single-cycle CSR reads and writes issued by the core's CSR control path in the 0xE0x CSR range, and answers with combinational read data. Holds a small CSR bank that programs and observes one NICE accelerator job. A job FSM launches the job, waits for the result, captures it, and raises status/interrupt. Sits inside the NICE coprocessor, between the core's NICE CSR port and the accelerator datapath.

---
 rtl/e203_nice_csr_resp_pkg.sv | 36 +++
 rtl/e203_nice_csr_job_fsm.sv | 76 +++++++
 rtl/e203_nice_csr_resp.sv | 147 ++++++++++++++
 tb/tb_e203_nice_csr_resp.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_nice_csr_resp_pkg.sv
// Shared CSR map, bit positions and job FSM encoding for the NICE CSR responder.
// The optional cycle counter is controlled by E203_NICE_CSR_CYCCNT_EN in the top.
package e203_nice_csr_resp_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'd0;
    localparam logic [3:0] OFF_STATUS = 4'd1;
    localparam logic [3:0] OFF_ARG0   = 4'd2;
    localparam logic [3:0] OFF_ARG1   = 4'd3;
    localparam logic [3:0] OFF_RESULT = 4'd4;
    localparam logic [3:0] OFF_CYCCNT = 4'd5;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_START    = 1;
    localparam int CTRL_IE       = 2;
    localparam int CTRL_MODE_LSB = 4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_OVR  = 3;

    typedef enum logic [1:0] {
        JOB_IDLE  = 2'd0,
        JOB_ISSUE = 2'd1,
        JOB_WAIT  = 2'd2,
        JOB_CAPT  = 2'd3
    } job_state_e;

    function automatic logic [31:0] pack_ctrl(input logic en, input logic ie, input logic [3:0] mode);
        pack_ctrl = 32'd0;
        pack_ctrl[CTRL_EN]                  = en;
        pack_ctrl[CTRL_IE]                  = ie;
        pack_ctrl[CTRL_MODE_LSB +: 4]       = mode;
    endfunction

endpackage

// File: rtl/e203_nice_csr_job_fsm.sv
// Job sequencer: launches one accelerator job from a snapshot of mode/args,
// waits for its result and holds the captured result for the CSR bank.
import e203_nice_csr_resp_pkg::*;

module e203_nice_csr_job_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [3:0]  mode_i,
    input  logic [31:0] arg0_i,
    input  logic [31:0] arg1_i,
    input  logic        job_ready_i,
    input  logic        rsp_valid_i,
    input  logic        rsp_err_i,
    input  logic [31:0] rsp_result_i,
    output logic        job_valid_o,
    output logic [3:0]  job_mode_o,
    output logic [31:0] job_arg0_o,
    output logic [31:0] job_arg1_o,
    output job_state_e  state_o,
    output logic [31:0] capt_result_o,
    output logic        capt_err_o
);

    job_state_e  state_q, state_d;
    logic [3:0]  mode_q;
    logic [31:0] arg0_q, arg1_q;
    logic [31:0] result_q;
    logic        err_q;

    always_comb begin
        state_d     = state_q;
        job_valid_o = 1'b0;
        case (state_q)
            JOB_IDLE:  if (start_i) state_d = JOB_ISSUE;
            JOB_ISSUE: begin
                job_valid_o = 1'b1;
                if (job_ready_i) state_d = JOB_WAIT;
            end
            JOB_WAIT:  if (rsp_valid_i) state_d = JOB_CAPT;
            JOB_CAPT:  state_d = JOB_IDLE;
            default:   state_d = JOB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= JOB_IDLE;
            mode_q   <= 4'd0;
            arg0_q   <= 32'd0;
            arg1_q   <= 32'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // Snapshot only at launch so later CSR writes cannot disturb a job in flight.
            if (state_q == JOB_IDLE && start_i) begin
                mode_q <= mode_i;
                arg0_q <= arg0_i;
                arg1_q <= arg1_i;
            end
            if (state_q == JOB_WAIT && rsp_valid_i) begin
                result_q <= rsp_result_i;
                err_q    <= rsp_err_i;
            end
        end
    end

    assign job_mode_o    = mode_q;
    assign job_arg0_o    = arg0_q;
    assign job_arg1_o    = arg1_q;
    assign state_o       = state_q;
    assign capt_result_o = result_q;
    assign capt_err_o    = err_q;

endmodule

// File: rtl/e203_nice_csr_resp.sv
// NICE CSR responder: CSR decode, register bank and read mux for one accelerator job.
// Define E203_NICE_CSR_CYCCNT_EN to add the busy-cycle counter at offset 5.
import e203_nice_csr_resp_pkg::*;

module e203_nice_csr_resp #(
    parameter logic [7:0] BASE_HI = 8'hE0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nice_csr_valid,
    output logic        nice_csr_ready,
    input  logic [31:0] nice_csr_addr,
    input  logic        nice_csr_wr,
    input  logic [31:0] nice_csr_wdata,
    output logic [31:0] nice_csr_rdata,
    output logic        job_valid,
    input  logic        job_ready,
    output logic [3:0]  job_mode,
    output logic [31:0] job_arg0,
    output logic [31:0] job_arg1,
    input  logic        rsp_valid,
    input  logic        rsp_err,
    input  logic [31:0] rsp_result,
    output logic        nice_busy,
    output logic        nice_irq
);

    job_state_e  state;
    logic [31:0] capt_result;
    logic        capt_err;

    logic        ctrl_en_q, ctrl_ie_q;
    logic [3:0]  ctrl_mode_q;
    logic        done_q, err_q, ovr_q;
    logic [31:0] arg0_q, arg1_q, result_q;

    logic        hit, wr_fire, wr_ctrl, wr_status, start_req, start_fire, idle;
    logic [3:0]  off;
    logic        unused_addr;

    assign unused_addr = ^nice_csr_addr[31:12];
    assign off         = nice_csr_addr[3:0];
    assign hit         = (nice_csr_addr[11:4] == BASE_HI);
    assign idle        = (state == JOB_IDLE);

    assign nice_csr_ready = (state != JOB_CAPT);
    assign wr_fire        = nice_csr_valid & nice_csr_ready & nice_csr_wr & hit;
    assign wr_ctrl        = wr_fire & (off == OFF_CTRL);
    assign wr_status      = wr_fire & (off == OFF_STATUS);
    assign start_req      = wr_ctrl & nice_csr_wdata[CTRL_START];
    // en is taken from the same write, not from the stored CTRL.en.
    assign start_fire     = start_req & nice_csr_wdata[CTRL_EN];

    e203_nice_csr_job_fsm u_job_fsm (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_fire),
        .mode_i        (nice_csr_wdata[CTRL_MODE_LSB +: 4]),
        .arg0_i        (arg0_q),
        .arg1_i        (arg1_q),
        .job_ready_i   (job_ready),
        .rsp_valid_i   (rsp_valid),
        .rsp_err_i     (rsp_err),
        .rsp_result_i  (rsp_result),
        .job_valid_o   (job_valid),
        .job_mode_o    (job_mode),
        .job_arg0_o    (job_arg0),
        .job_arg1_o    (job_arg1),
        .state_o       (state),
        .capt_result_o (capt_result),
        .capt_err_o    (capt_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en_q   <= 1'b0;
            ctrl_ie_q   <= 1'b0;
            ctrl_mode_q <= 4'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            arg0_q      <= 32'd0;
            arg1_q      <= 32'd0;
            result_q    <= 32'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en_q   <= nice_csr_wdata[CTRL_EN];
                ctrl_ie_q   <= nice_csr_wdata[CTRL_IE];
                ctrl_mode_q <= nice_csr_wdata[CTRL_MODE_LSB +: 4];
            end
            if (wr_fire && off == OFF_ARG0) arg0_q <= nice_csr_wdata;
            if (wr_fire && off == OFF_ARG1) arg1_q <= nice_csr_wdata;
            if (wr_status) begin
                if (nice_csr_wdata[STAT_DONE]) done_q <= 1'b0;
                if (nice_csr_wdata[STAT_ERR])  err_q  <= 1'b0;
                if (nice_csr_wdata[STAT_OVR])  ovr_q  <= 1'b0;
            end
            if (start_fire && idle) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (start_req && !idle) ovr_q <= 1'b1;
            // CSR writes cannot fire during CAPT (ready=0), so capture never collides with them.
            if (state == JOB_CAPT) begin
                result_q <= capt_result;
                done_q   <= 1'b1;
                err_q    <= capt_err;
            end
        end
    end

`ifdef E203_NICE_CSR_CYCCNT_EN
    logic [31:0] cyccnt_q, cyccnt_d;

    always_comb begin
        cyccnt_d = cyccnt_q;
        if (wr_fire && off == OFF_CYCCNT) cyccnt_d = nice_csr_wdata;
        else if (!idle)                   cyccnt_d = cyccnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyccnt_q <= 32'd0;
        else     cyccnt_q <= cyccnt_d;
    end
`endif

    always_comb begin
        nice_csr_rdata = 32'd0;
        if (hit) begin
            case (off)
                OFF_CTRL:   nice_csr_rdata = pack_ctrl(ctrl_en_q, ctrl_ie_q, ctrl_mode_q);
                OFF_STATUS: nice_csr_rdata = {28'd0, ovr_q, err_q, done_q, !idle};
                OFF_ARG0:   nice_csr_rdata = arg0_q;
                OFF_ARG1:   nice_csr_rdata = arg1_q;
                OFF_RESULT: nice_csr_rdata = result_q;
`ifdef E203_NICE_CSR_CYCCNT_EN
                OFF_CYCCNT: nice_csr_rdata = cyccnt_q;
`endif
                default:    nice_csr_rdata = 32'd0;
            endcase
        end
    end

    assign nice_busy = !idle;
    assign nice_irq  = done_q & ctrl_ie_q;

endmodule

// File: tb/tb_e203_nice_csr_resp.sv
// Directed bench for e203_nice_csr_resp with a cycle-level behavioural model and literal pins.
module tb_e203_nice_csr_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nice_csr_valid = 1'b0;
    logic        nice_csr_ready;
    logic [31:0] nice_csr_addr = 32'h0;
    logic        nice_csr_wr = 1'b0;
    logic [31:0] nice_csr_wdata = 32'h0;
    logic [31:0] nice_csr_rdata;
    logic        job_valid;
    logic        job_ready = 1'b0;
    logic [3:0]  job_mode;
    logic [31:0] job_arg0, job_arg1;
    logic        rsp_valid = 1'b0;
    logic        rsp_err = 1'b0;
    logic [31:0] rsp_result = 32'h0;
    logic        nice_busy, nice_irq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    e203_nice_csr_resp dut (
        .clk            (clk),
        .rst            (rst),
        .nice_csr_valid (nice_csr_valid),
        .nice_csr_ready (nice_csr_ready),
        .nice_csr_addr  (nice_csr_addr),
        .nice_csr_wr    (nice_csr_wr),
        .nice_csr_wdata (nice_csr_wdata),
        .nice_csr_rdata (nice_csr_rdata),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_mode       (job_mode),
        .job_arg0       (job_arg0),
        .job_arg1       (job_arg1),
        .rsp_valid      (rsp_valid),
        .rsp_err        (rsp_err),
        .rsp_result     (rsp_result),
        .nice_busy      (nice_busy),
        .nice_irq       (nice_irq)
    );

    // Behavioural model: phase 0 none, 1 offering job, 2 job running, 3 result arriving.
    int          m_phase;
    logic        m_en, m_ie, m_done, m_err, m_ovr, m_lat_err;
    logic [3:0]  m_mode, m_snap_mode;
    logic [31:0] m_arg0, m_arg1, m_result, m_cyc, m_snap_arg0, m_snap_arg1, m_lat_res;

    logic        lit_en = 1'b0;
    logic [31:0] lit_exp = 32'h0;
    string       lit_nm = "";

    task automatic m_reset();
        m_phase = 0; m_en = 0; m_ie = 0; m_done = 0; m_err = 0; m_ovr = 0; m_lat_err = 0;
        m_mode = 0; m_snap_mode = 0; m_arg0 = 0; m_arg1 = 0; m_result = 0; m_cyc = 0;
        m_snap_arg0 = 0; m_snap_arg1 = 0; m_lat_res = 0;
    endtask

    function automatic logic [31:0] m_rdata(input logic [31:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a[11:4] == 8'hE0) begin
            case (a[3:0])
                4'd0: r = {24'h0, m_mode, 1'b0, m_ie, 1'b0, m_en};
                4'd1: r = {28'h0, m_ovr, m_err, m_done, (m_phase != 0)};
                4'd2: r = m_arg0;
                4'd3: r = m_arg1;
                4'd4: r = m_result;
`ifdef E203_NICE_CSR_CYCCNT_EN
                4'd5: r = m_cyc;
`endif
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    task automatic m_step();
        int p0;
        logic w;
        logic [31:0] wd;
        p0 = m_phase;
        wd = nice_csr_wdata;
        w  = nice_csr_valid && (p0 != 3) && nice_csr_wr && (nice_csr_addr[11:4] == 8'hE0);
        case (p0)
            1: if (job_ready) m_phase = 2;
            2: if (rsp_valid) begin m_lat_res = rsp_result; m_lat_err = rsp_err; m_phase = 3; end
            3: begin m_result = m_lat_res; m_done = 1; m_err = m_lat_err; m_phase = 0; end
            default: ;
        endcase
`ifdef E203_NICE_CSR_CYCCNT_EN
        if (w && nice_csr_addr[3:0] == 4'd5) m_cyc = wd;
        else if (p0 != 0) m_cyc = m_cyc + 32'd1;
`endif
        if (w) begin
            case (nice_csr_addr[3:0])
                4'd0: begin
                    m_en = wd[0]; m_ie = wd[2]; m_mode = wd[7:4];
                    if (wd[1]) begin
                        if (p0 == 0 && wd[0]) begin
                            m_snap_mode = wd[7:4]; m_snap_arg0 = m_arg0; m_snap_arg1 = m_arg1;
                            m_done = 0; m_err = 0; m_phase = 1;
                        end else if (p0 != 0) begin
                            m_ovr = 1;
                        end
                    end
                end
                4'd1: begin
                    if (wd[1]) m_done = 0;
                    if (wd[2]) m_err = 0;
                    if (wd[3]) m_ovr = 0;
                end
                4'd2: m_arg0 = wd;
                4'd3: m_arg1 = wd;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One clock: compare all outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        @(negedge clk);
        chk("ready", {31'h0, nice_csr_ready}, {31'h0, m_phase != 3});
        chk("job_valid", {31'h0, job_valid}, {31'h0, m_phase == 1});
        chk("busy", {31'h0, nice_busy}, {31'h0, m_phase != 0});
        chk("irq", {31'h0, nice_irq}, {31'h0, m_done & m_ie});
        chk("rdata", nice_csr_rdata, m_rdata(nice_csr_addr));
        if (m_phase == 1) begin
            chk("job_mode", {28'h0, job_mode}, {28'h0, m_snap_mode});
            chk("job_arg0", job_arg0, m_snap_arg0);
            chk("job_arg1", job_arg1, m_snap_arg1);
        end
        if (lit_en) chk(lit_nm, nice_csr_rdata, lit_exp);
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        nice_csr_valid = 1; nice_csr_wr = 1; nice_csr_addr = {20'h0, a}; nice_csr_wdata = d;
        cycle();
        $display("WR  addr=0x%03h data=0x%08h", a, d);
        nice_csr_valid = 0; nice_csr_wr = 0;
    endtask

    task automatic csr_rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
        nice_csr_valid = 1; nice_csr_wr = 0; nice_csr_addr = {20'h0, a};
        lit_en = 1; lit_exp = exp; lit_nm = nm;
        cycle();
        $display("RD  addr=0x%03h expect=0x%08h", a, exp);
        lit_en = 0; nice_csr_valid = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < 8; i++) csr_rd(12'hE00 + 12'(i), 32'h0, "reset_read");
        chk("reset_ready", {31'h0, nice_csr_ready}, 32'h1);

        csr_wr(12'hE02, 32'h12345678);
        csr_wr(12'hE03, 32'h00000009);
        csr_wr(12'hE00, 32'h00000033);
        chk("launch_valid", {31'h0, job_valid}, 32'h1);
        chk("launch_mode", {28'h0, job_mode}, 32'h3);
        chk("launch_arg0", job_arg0, 32'h12345678);
        chk("launch_arg1", job_arg1, 32'h9);
        idle(3);
        chk("hold_valid", {31'h0, job_valid}, 32'h1);
        job_ready = 1; cycle(); job_ready = 0;
        $display("JOB accepted");

        csr_wr(12'hE02, 32'h0000FFFF);
        chk("snap_arg0", job_arg0, 32'h12345678);
        csr_rd(12'hE02, 32'h0000FFFF, "arg0_readback");
        csr_wr(12'hE00, 32'h00000037);
        chk("ovr_no_job", {31'h0, job_valid}, 32'h0);
        csr_rd(12'hE01, 32'h00000009, "status_ovr");
        csr_wr(12'hE01, 32'h00000008);
        csr_rd(12'hE01, 32'h00000001, "status_ovr_clr");

        rsp_valid = 1; rsp_result = 32'hCAFEF00D; rsp_err = 0; cycle();
        rsp_valid = 0; rsp_result = 32'h0;
        $display("RSP result=0xCAFEF00D err=0");
        chk("capt_ready", {31'h0, nice_csr_ready}, 32'h0);
        cycle();
        chk("post_capt_ready", {31'h0, nice_csr_ready}, 32'h1);
        chk("irq_set", {31'h0, nice_irq}, 32'h1);
        csr_rd(12'hE04, 32'hCAFEF00D, "result");
        csr_rd(12'hE01, 32'h00000002, "status_done");
        csr_wr(12'hE01, 32'h00000002);
        chk("irq_clr", {31'h0, nice_irq}, 32'h0);

        csr_wr(12'hE00, 32'h00000002);
        chk("start_no_en", {31'h0, job_valid}, 32'h0);
        csr_wr(12'h7E2, 32'hDEADBEEF);
        csr_rd(12'h7E2, 32'h0, "miss_read");
        csr_rd(12'hE02, 32'h0000FFFF, "miss_no_write");
        csr_rd(12'hE07, 32'h0, "unmapped");

        csr_wr(12'hE05, 32'hFFFFFFFE);
        csr_wr(12'hE00, 32'h00000013);
`ifdef E203_NICE_CSR_CYCCNT_EN
        csr_rd(12'hE05, 32'hFFFFFFFE, "cyc_0");
        csr_rd(12'hE05, 32'hFFFFFFFF, "cyc_1");
        csr_rd(12'hE05, 32'h00000000, "cyc_wrap");
        csr_rd(12'hE05, 32'h00000001, "cyc_after");
`else
        for (int i = 0; i < 4; i++) csr_rd(12'hE05, 32'h0, "cyc_absent");
`endif
        job_ready = 1; cycle(); job_ready = 0;
        idle(1);
        rsp_valid = 1; rsp_result = 32'h000000A5; rsp_err = 1; cycle();
        rsp_valid = 0; rsp_err = 0;
        $display("RSP result=0x000000A5 err=1");
        idle(1);
        csr_rd(12'hE04, 32'h000000A5, "result_err");
        csr_rd(12'hE01, 32'h00000006, "status_err");

        csr_wr(12'hE00, 32'h00000003);
        chk("relaunch", {31'h0, job_valid}, 32'h1);
        #2 rst = 1;
        #1;
        chk("async_rst_valid", {31'h0, job_valid}, 32'h0);
        chk("async_rst_busy", {31'h0, nice_busy}, 32'h0);
        chk("async_rst_ready", {31'h0, nice_csr_ready}, 32'h1);
        $display("RST asserted mid-job");
        m_reset();
        @(posedge clk);
        #1 rst = 0;
        csr_rd(12'hE01, 32'h0, "post_rst_status");
        csr_rd(12'hE00, 32'h0, "post_rst_ctrl");
        csr_rd(12'hE04, 32'h0, "post_rst_result");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
